// File: rtl/scan_mux.sv
// scan_mux: registered CHANNELS:1 mux, manual select or auto round-robin scan with dwell/hold; in din/sel/mode/dwell/hold, out dout/dout_valid/cur_ch/wrap
module scan_mux #(
  parameter int WIDTH = 1,
  parameter int CHANNELS = 4,
  parameter int SEL_W = $clog2(CHANNELS),
  parameter int DWELL_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic [DWELL_W-1:0]        dwell,
  input  logic                      hold,
  output logic [WIDTH-1:0]          dout,
  output logic                      dout_valid,
  output logic [SEL_W-1:0]          cur_ch,
  output logic                      wrap
);
  localparam logic [SEL_W:0] nch = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] last = SEL_W'(CHANNELS-1);
  logic [DWELL_W-1:0] cnt, nxt_cnt;
  logic [SEL_W-1:0] nxt_ch;
  logic adv, nxt_wrap;
  always_comb begin
    adv = !hold && mode && cnt == dwell;
    nxt_ch = hold ? cur_ch
           : !mode ? ({1'b0, sel} < nch ? sel : cur_ch)
           : adv ? (cur_ch == last ? '0 : cur_ch + 1'b1)
           : cur_ch;
    nxt_cnt = hold ? cnt : (!mode || adv) ? '0 : cnt + 1'b1;
    nxt_wrap = adv && cur_ch == last;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
      dout_valid <= 1'b0;
      cur_ch <= '0;
      cnt <= '0;
      wrap <= 1'b0;
    end else begin
      dout <= din[int'(nxt_ch)*WIDTH +: WIDTH];
      dout_valid <= 1'b1;
      cur_ch <= nxt_ch;
      cnt <= nxt_cnt;
      wrap <= nxt_wrap;
    end
  end
endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux: table vectors, directed corner sequences and random stimulus against a behavioural model, on a 4x8 and a 3x4 instance
module tb_scan_mux;
  logic clk = 0, rst = 1;
  logic [31:0] din_a;
  logic [11:0] din_b;
  logic [1:0] sel;
  logic mode, hold;
  logic [7:0] dwell;
  logic [7:0] dout_a;
  logic [3:0] dout_b;
  logic val_a, val_b, wrap_a, wrap_b;
  logic [1:0] cur_a, cur_b;
  int total = 0, passed = 0;
  int ma_ch, ma_cnt, mb_ch, mb_cnt;
  logic ma_wr, mb_wr, m_val;
  logic [31:0] ma_dq, mb_dq;

  always #5 clk = ~clk;

  scan_mux #(.WIDTH(8), .CHANNELS(4)) u_a (
    .clk(clk), .rst(rst), .din(din_a), .sel(sel), .mode(mode), .dwell(dwell), .hold(hold),
    .dout(dout_a), .dout_valid(val_a), .cur_ch(cur_a), .wrap(wrap_a));
  scan_mux #(.WIDTH(4), .CHANNELS(3)) u_b (
    .clk(clk), .rst(rst), .din(din_b), .sel(sel), .mode(mode), .dwell(dwell), .hold(hold),
    .dout(dout_b), .dout_valid(val_b), .cur_ch(cur_b), .wrap(wrap_b));

  typedef struct {
    logic [1:0] sel;
    logic [7:0] ea;
    logic [1:0] ca;
    logic [3:0] eb;
    logic [1:0] cb;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // One clock of the scanner described as "which channel is shown, how long has it been shown"
  task automatic model(input int c, input int w, input logic [31:0] d,
                       inout int ch, inout int cnt, inout logic wr, inout logic [31:0] dq);
    wr = 1'b0;
    if (hold) begin
    end else if (!mode) begin
      if (int'(sel) < c) ch = int'(sel);
      cnt = 0;
    end else if (cnt == int'(dwell)) begin
      ch = (ch + 1) % c;
      wr = (ch == 0);
      cnt = 0;
    end else cnt = (cnt + 1) % 256;
    dq = (d >> (ch * w)) & ((32'd1 << w) - 1);
  endtask

  task automatic model_reset();
    ma_ch = 0; ma_cnt = 0; mb_ch = 0; mb_cnt = 0;
    ma_wr = 0; mb_wr = 0; m_val = 0; ma_dq = 0; mb_dq = 0;
  endtask

  task automatic check_all();
    chk("dout_a", dout_a, ma_dq);
    chk("cur_a", cur_a, ma_ch);
    chk("wrap_a", wrap_a, ma_wr);
    chk("valid_a", val_a, m_val);
    chk("dout_b", dout_b, mb_dq);
    chk("cur_b", cur_b, mb_ch);
    chk("wrap_b", wrap_b, mb_wr);
    chk("valid_b", val_b, m_val);
  endtask

  task automatic step();
    model(4, 8, din_a, ma_ch, ma_cnt, ma_wr, ma_dq);
    model(3, 4, {20'd0, din_b}, mb_ch, mb_cnt, mb_wr, mb_dq);
    m_val = 1'b1;
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    int wraps, start, n;
    tbl[0] = '{2'd0, 8'h11, 2'd0, 4'hA, 2'd0};
    tbl[1] = '{2'd1, 8'h22, 2'd1, 4'hB, 2'd1};
    tbl[2] = '{2'd2, 8'h33, 2'd2, 4'hC, 2'd2};
    tbl[3] = '{2'd3, 8'h44, 2'd3, 4'hC, 2'd2};
    tbl[4] = '{2'd1, 8'h22, 2'd1, 4'hB, 2'd1};
    tbl[5] = '{2'd3, 8'h44, 2'd3, 4'hB, 2'd1};
    tbl[6] = '{2'd2, 8'h33, 2'd2, 4'hC, 2'd2};
    din_a = 32'h44332211; din_b = 12'hCBA;
    sel = 0; mode = 0; hold = 0; dwell = 0;
    model_reset();
    #2;
    check_all();
    #10 rst = 0;
    for (int i = 0; i < 7; i++) begin
      sel = tbl[i].sel;
      step();
      chk("tbl_dout_a", dout_a, tbl[i].ea);
      chk("tbl_cur_a", cur_a, tbl[i].ca);
      chk("tbl_dout_b", dout_b, tbl[i].eb);
      chk("tbl_cur_b", cur_b, tbl[i].cb);
    end
    // auto scan dwell=2 from channel 0
    sel = 0; step();
    mode = 1; dwell = 2; wraps = 0;
    for (int k = 1; k <= 24; k++) begin
      step();
      chk("scan_cur", cur_a, (k / 3) % 4);
      chk("scan_dout", dout_a, 8'h11 * (((k / 3) % 4) + 1));
      chk("scan_wrap", wrap_a, (k % 12) == 0);
      wraps += int'(wrap_a);
    end
    chk("scan_wrap_count", wraps, 2);
    // dwell=0 on the 3-channel instance
    mode = 0; sel = 0; step();
    mode = 1; dwell = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("fast_cur_b", cur_b, k % 3);
      chk("fast_wrap_b", wrap_b, (k % 3) == 0);
    end
    // hold at channel 2 with count 1, dwell 3
    mode = 0; sel = 0; step();
    mode = 1; dwell = 3; n = 0;
    while (!(ma_ch == 2 && ma_cnt == 1) && n < 50) begin step(); n++; end
    chk("hold_reach", n < 50, 1);
    hold = 1;
    for (int k = 0; k < 5; k++) begin
      din_a[23:16] = (k % 2) ? 8'h5A : 8'hA5;
      step();
      chk("hold_cur", cur_a, 2);
      chk("hold_dout", dout_a, din_a[23:16]);
    end
    hold = 0;
    step(); chk("rel_1", cur_a, 2);
    step(); chk("rel_2", cur_a, 2);
    step(); chk("rel_adv", cur_a, 3);
    // async reset between edges at channel 3
    din_a = 32'h44332211; dwell = 0; n = 0;
    while (ma_ch != 3 && n < 20) begin step(); n++; end
    chk("rst_reach", cur_a, 3);
    #2 rst = 1;
    #1;
    model_reset();
    check_all();
    #1 rst = 0;
    dwell = 2;
    step(); chk("rst_restart", cur_a, 0);
    step();
    // randomized
    for (int k = 0; k < 400; k++) begin
      din_a = $urandom; din_b = 12'($urandom);
      sel = 2'($urandom);
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      hold = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 29) == 0) dwell = 8'($urandom_range(0, 3));
      step();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/scan_mux.md
# scan_mux

Parametrised, registered N-channel multiplexer with manual select and automatic round-robin scan modes. Generalises the project's 4:1 single-bit combinational mux to CHANNELS inputs of WIDTH bits each. Adds a registered output, a programmable per-channel dwell time, hold/freeze and a wrap indication. It sits between the tile's dedicated inputs and outputs in the top-level wrapper, and is also reusable internally wherever a scanned channel selector is needed.

## Interface
Parameters:
- WIDTH, 1: bits per channel.
- CHANNELS, 4: number of input channels, ≥2.
- SEL_W, $clog2(CHANNELS): width of the select and channel index.
- DWELL_W, 8: width of the dwell counter and the dwell input.

Ports:
- clk  in  1: single clock, rising edge.
- rst  in  1: asynchronous, active-high reset.
- din  in  CHANNELS*WIDTH: channel k is din[k*WIDTH +: WIDTH].
- sel  in  SEL_W: channel select used in manual mode.
- mode  in  1: 0 = manual, 1 = auto-scan.
- dwell  in  DWELL_W: in auto mode, each channel is held for dwell+1 cycles.
- hold  in  1: freezes the channel index and the dwell counter.
- dout  out  WIDTH: registered selected data.
- dout_valid  out  1: dout holds sampled data.
- cur_ch  out  SEL_W: channel index that dout was sampled from.
- wrap  out  1: one-cycle pulse on the auto-scan advance from CHANNELS-1 to 0.

## Operation
- Reset values: dout=0, dout_valid=0, cur_ch=0, internal dwell counter cnt=0, wrap=0.
- Every edge: compute nxt_ch, then cur_ch <= nxt_ch and dout <= din slice nxt_ch. dout and cur_ch always agree in the same cycle.
- dout_valid <= 1 on every edge out of reset, and stays 1 until the next reset.
- Manual (mode=0):
  - nxt_ch = sel if sel < CHANNELS; otherwise nxt_ch = cur_ch, so an out-of-range select keeps the previous channel.
  - cnt <= 0 and wrap=0.
- Auto (mode=1, hold=0):
  - If cnt == dwell: cnt <= 0, and nxt_ch = cur_ch+1, or 0 if cur_ch == CHANNELS-1.
  - wrap <= 1 only on the advance from CHANNELS-1 to 0.
  - Otherwise: cnt <= cnt+1, nxt_ch = cur_ch, wrap <= 0.
  - dwell=0 advances the channel every cycle.
- hold=1, either mode:
  - nxt_ch = cur_ch, cnt is unchanged, wrap <= 0.
  - dout keeps resampling the frozen channel every edge (live data, frozen index).
  - hold takes priority over both sel and the auto advance.
- Mode switch manual→auto: the scan starts from the current cur_ch with cnt=0, because cnt is held at 0 in manual mode.
- Mode switch auto→manual: nxt_ch = sel on the first manual edge, and cnt clears.
- dwell changed mid-count: the new value is compared on the next edge. If cnt > new dwell, the counter counts up through the DWELL_W wrap before the next advance. This is accepted behaviour, not an error.
- CHANNELS not a power of two: index values ≥ CHANNELS are never reached in auto mode and are rejected in manual mode.

## Timing
- Latency: a change on din or sel before edge N appears on dout/cur_ch after edge N (1 cycle). There is no combinational path from input to output.
- In auto mode with steady dwell=D, each channel is presented for exactly D+1 cycles. A full scan takes CHANNELS*(D+1) cycles.
- wrap is asserted in the same cycle that cur_ch becomes 0 from an auto advance.
- rst asserted mid-operation clears all state immediately, without waiting for clk.
- On rst deassertion: the first edge samples per the current mode. In auto mode that means channel 0 for dwell+1 cycles.

## Test plan
- Manual, CHANNELS=4, WIDTH=1, din=4'b1010, sel sweeps 0..3: dout = 0,1,0,1, each 1 cycle after sel. This reproduces the original 4:1 truth table, registered.
- Auto, CHANNELS=4, WIDTH=8, din={8'h44,8'h33,8'h22,8'h11}, dwell=2: dout = 11×3, 22×3, 33×3, 44×3, then repeats. wrap=1 for one cycle when dout returns to 11.
- Auto, dwell=0, CHANNELS=3: cur_ch = 0,1,2,0,1,2 on consecutive cycles. wrap pulses every third cycle.
- hold asserted during auto at cur_ch=2 with cnt=1 for 5 cycles, while din[2] toggles: cur_ch stays 2 and dout follows din[2]. After release, the advance occurs after dwell-1 further cycles.
- CHANNELS=3, manual sel=1, then sel=3: cur_ch stays 1 and dout continues tracking din[1].
- rst pulsed asynchronously between edges during auto scan at cur_ch=3: dout=0, dout_valid=0, cur_ch=0 immediately. After release, the scan restarts at channel 0 and dout_valid=1 after the first edge.
